// File: rtl/mips_hazard_pkg.sv
// Shared types and constants for the MIPS pipeline hazard / stall controller.
package mips_hazard_pkg;

  // Register-file index width
  localparam int REG_W = 5;

  // Default multiply/divide latency in cycles
  localparam int MD_LAT_DEFAULT = 32;

  // Multiply/divide unit occupancy state
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } md_state_e;

  // True when a nonzero register r is read by the ID-stage instruction
  function automatic logic reg_match(
    input logic [REG_W-1:0] r,
    input logic [REG_W-1:0] rs,
    input logic [REG_W-1:0] rt,
    input logic             uses_rt
  );
    return (r != {REG_W{1'b0}}) && ((r == rs) || (uses_rt && (r == rt)));
  endfunction

endpackage

// File: rtl/md_busy_timer.sv
// Multiply/divide occupancy timer: IDLE -> BUSY (MD_LAT-1 cycles) -> DONE (1 cycle).
// A new operation may start straight out of DONE; md_start is ignored while BUSY.
module md_busy_timer
  import mips_hazard_pkg::*;
#(
  parameter int MD_LAT = MD_LAT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic md_start,
  output logic md_busy,
  output logic md_done,
  output logic md_active
);

  // BUSY lasts cnt_load+1 cycles, so loading MD_LAT-2 gives MD_LAT-1 busy cycles
  localparam logic [5:0] CNT_LOAD = 6'(MD_LAT - 2);

  md_state_e  state_q, state_d;
  logic [5:0] cnt_q, cnt_d;

  // State and countdown registers; reset aborts any operation in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and countdown logic; cnt never decrements below zero
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (md_start) begin
          state_d = BUSY;
          cnt_d   = CNT_LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (cnt_q == 6'd0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end
      DONE: begin
        if (md_start) begin
          state_d = BUSY;
          cnt_d   = CNT_LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 6'd0;
      end
    endcase
  end

  // Status outputs decoded from the state register
  always_comb begin
    md_busy   = 1'b0;
    md_done   = 1'b0;
    md_active = 1'b0;
    case (state_q)
      IDLE: begin
        md_active = 1'b0;
      end
      BUSY: begin
        md_busy   = 1'b1;
        md_active = 1'b1;
      end
      DONE: begin
        md_done   = 1'b1;
        md_active = 1'b1;
      end
      default: begin
        md_active = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline stall/flush controller: load-use, branch-in-ID and mult/div hazards.
// Optional feature macro: STALL_PERF_EN enables a saturating stall-cycle counter.
module pipeline_stall_ctrl
  import mips_hazard_pkg::*;
#(
  parameter int MD_LAT = MD_LAT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] IFID_Rs,
  input  logic [REG_W-1:0] IFID_Rt,
  input  logic             IFID_UsesRt,
  input  logic             IFID_Branch,
  input  logic             IFID_MdUse,
  input  logic [REG_W-1:0] IDEX_Rd,
  input  logic             IDEX_RegWr,
  input  logic             IDEX_MemRd,
  input  logic [REG_W-1:0] EXMEM_Rd,
  input  logic             EXMEM_MemRd,
  input  logic             md_start,
  input  logic             branch_taken,
  output logic             PC_Wr,
  output logic             IFID_Wr,
  output logic             IFID_Flush,
  output logic             IDEX_Flush,
  output logic             md_busy,
  output logic             md_done,
  output logic [31:0]      perf_stall_cnt
);

  logic md_active_s;
  logic load_use_s;
  logic br_haz_s;
  logic md_haz_s;
  logic stall_s;

  md_busy_timer #(
    .MD_LAT (MD_LAT)
  ) u_md_timer (
    .clk       (clk),
    .rst       (rst),
    .md_start  (md_start),
    .md_busy   (md_busy),
    .md_done   (md_done),
    .md_active (md_active_s)
  );

  // Hazard detection; reset masks the stall so the pipeline stays writable
  always_comb begin
    load_use_s = IDEX_MemRd && reg_match(IDEX_Rd, IFID_Rs, IFID_Rt, IFID_UsesRt);
    br_haz_s   = IFID_Branch &&
                 ((IDEX_RegWr && reg_match(IDEX_Rd, IFID_Rs, IFID_Rt, IFID_UsesRt)) ||
                  (EXMEM_MemRd && reg_match(EXMEM_Rd, IFID_Rs, IFID_Rt, IFID_UsesRt)));
    md_haz_s   = IFID_MdUse && md_active_s;
    stall_s    = !rst && (load_use_s || br_haz_s || md_haz_s);
  end

  // Write enables and bubble inserts; a stall suppresses the taken-branch flush
  always_comb begin
    PC_Wr      = !stall_s;
    IFID_Wr    = !stall_s;
    IDEX_Flush = stall_s;
    IFID_Flush = !rst && branch_taken && !stall_s;
  end

`ifdef STALL_PERF_EN
  logic [31:0] perf_cnt_q, perf_cnt_d;

  // Saturating count of stalled cycles
  always_comb begin
    if (stall_s && (perf_cnt_q != 32'hFFFF_FFFF)) begin
      perf_cnt_d = perf_cnt_q + 32'd1;
    end else begin
      perf_cnt_d = perf_cnt_q;
    end
  end

  // Stall counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_cnt_q <= 32'd0;
    end else begin
      perf_cnt_q <= perf_cnt_d;
    end
  end

  assign perf_stall_cnt = perf_cnt_q;
`else
  assign perf_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl (MD_LAT = 4): directed cases with
// literal expectations plus randomized cycles against a behavioural model.
module tb_pipeline_stall_ctrl;

  localparam int MDL = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  IFID_Rs, IFID_Rt, IDEX_Rd, EXMEM_Rd;
  logic        IFID_UsesRt, IFID_Branch, IFID_MdUse;
  logic        IDEX_RegWr, IDEX_MemRd, EXMEM_MemRd;
  logic        md_start, branch_taken;
  logic        PC_Wr, IFID_Wr, IFID_Flush, IDEX_Flush, md_busy, md_done;
  logic [31:0] perf_stall_cnt;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: remaining busy cycles, done pulse, stall count
  int     m_busy_rem = 0;
  bit     m_done     = 1'b0;
  longint m_perf     = 0;

  pipeline_stall_ctrl #(.MD_LAT(MDL)) dut (
    .clk(clk), .rst(rst),
    .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt), .IFID_UsesRt(IFID_UsesRt),
    .IFID_Branch(IFID_Branch), .IFID_MdUse(IFID_MdUse),
    .IDEX_Rd(IDEX_Rd), .IDEX_RegWr(IDEX_RegWr), .IDEX_MemRd(IDEX_MemRd),
    .EXMEM_Rd(EXMEM_Rd), .EXMEM_MemRd(EXMEM_MemRd),
    .md_start(md_start), .branch_taken(branch_taken),
    .PC_Wr(PC_Wr), .IFID_Wr(IFID_Wr), .IFID_Flush(IFID_Flush), .IDEX_Flush(IDEX_Flush),
    .md_busy(md_busy), .md_done(md_done), .perf_stall_cnt(perf_stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic bit reads(input logic [4:0] r);
    return (r != 5'd0) && (r == IFID_Rs || (IFID_UsesRt && r == IFID_Rt));
  endfunction

  function automatic bit exp_stall();
    bit lu, br, md;
    lu = IDEX_MemRd && reads(IDEX_Rd);
    br = IFID_Branch && ((IDEX_RegWr && reads(IDEX_Rd)) || (EXMEM_MemRd && reads(EXMEM_Rd)));
    md = IFID_MdUse && (m_busy_rem > 0 || m_done);
    return !rst && (lu || br || md);
  endfunction

  function automatic longint exp_perf();
`ifdef STALL_PERF_EN
    return m_perf;
`else
    return 0;
`endif
  endfunction

  // Model update: async reset, otherwise advance one cycle on the clock edge
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy_rem <= 0;
      m_done     <= 1'b0;
      m_perf     <= 0;
    end else begin
      if (exp_stall() && m_perf < 64'h0000_0000_FFFF_FFFF) m_perf <= m_perf + 1;
      if (m_done) begin
        m_done <= 1'b0;
        if (md_start) m_busy_rem <= MDL - 1;
      end else if (m_busy_rem > 0) begin
        m_busy_rem <= m_busy_rem - 1;
        if (m_busy_rem == 1) m_done <= 1'b1;
      end else if (md_start) begin
        m_busy_rem <= MDL - 1;
      end
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Compare every output against the model
  task automatic compare_model();
    bit s;
    s = exp_stall();
    chk("PC_Wr", PC_Wr, !s);
    chk("IFID_Wr", IFID_Wr, !s);
    chk("IDEX_Flush", IDEX_Flush, s);
    chk("IFID_Flush", IFID_Flush, !rst && branch_taken && !s);
    chk("md_busy", md_busy, m_busy_rem > 0);
    chk("md_done", md_done, m_done);
    chk("perf_stall_cnt", perf_stall_cnt, exp_perf());
  endtask

  // Start a cycle: wait for the inactive edge and clear data inputs
  task automatic cyc_begin();
    @(negedge clk);
    IFID_Rs = 5'd0; IFID_Rt = 5'd0; IFID_UsesRt = 1'b0; IFID_Branch = 1'b0;
    IFID_MdUse = 1'b0; IDEX_Rd = 5'd0; IDEX_RegWr = 1'b0; IDEX_MemRd = 1'b0;
    EXMEM_Rd = 5'd0; EXMEM_MemRd = 1'b0; md_start = 1'b0; branch_taken = 1'b0;
  endtask

  task automatic cyc_check();
    #1;
    compare_model();
  endtask

  task automatic do_reset();
    cyc_begin();
    rst = 1'b1;
    cyc_check();
    cyc_begin();
    rst = 1'b0;
    cyc_check();
  endtask

  initial begin
    // Reset with hazard-looking inputs: outputs must be the reset values
    cyc_begin();
    rst = 1'b1;
    IDEX_MemRd = 1'b1; IDEX_Rd = 5'd8; IFID_Rs = 5'd8; branch_taken = 1'b1; md_start = 1'b1;
    cyc_check();
    chk("rst_PC_Wr", PC_Wr, 1); chk("rst_IFID_Wr", IFID_Wr, 1);
    chk("rst_IFID_Flush", IFID_Flush, 0); chk("rst_IDEX_Flush", IDEX_Flush, 0);
    chk("rst_md_busy", md_busy, 0); chk("rst_md_done", md_done, 0);
    chk("rst_perf", perf_stall_cnt, 0);
    cyc_begin();
    rst = 1'b0;
    cyc_check();

    // Load-use stall for exactly one cycle
    cyc_begin();
    IDEX_MemRd = 1'b1; IDEX_Rd = 5'd8; IFID_Rs = 5'd8;
    cyc_check();
    chk("lu_PC_Wr", PC_Wr, 0); chk("lu_IDEX_Flush", IDEX_Flush, 1);
    cyc_begin();
    cyc_check();
    chk("lu_after_PC_Wr", PC_Wr, 1); chk("lu_after_IDEX_Flush", IDEX_Flush, 0);

    // Register 0 never creates a hazard
    cyc_begin();
    IDEX_MemRd = 1'b1; IDEX_Rd = 5'd0; IFID_Rs = 5'd0;
    cyc_check();
    chk("rd0_PC_Wr", PC_Wr, 1); chk("rd0_IDEX_Flush", IDEX_Flush, 0);

    // Branch on a loaded Rt: stall wins over the taken-branch flush
    cyc_begin();
    IFID_Branch = 1'b1; EXMEM_MemRd = 1'b1; EXMEM_Rd = 5'd5; IFID_Rt = 5'd5;
    IFID_UsesRt = 1'b1; branch_taken = 1'b1; IFID_Rs = 5'd1;
    cyc_check();
    chk("br_IFID_Flush", IFID_Flush, 0); chk("br_IDEX_Flush", IDEX_Flush, 1);
    // Same branch with no hazard: taken flush goes through
    cyc_begin();
    IFID_Branch = 1'b1; branch_taken = 1'b1; IFID_Rs = 5'd1; IFID_Rt = 5'd5; IFID_UsesRt = 1'b1;
    cyc_check();
    chk("brok_IFID_Flush", IFID_Flush, 1); chk("brok_IDEX_Flush", IDEX_Flush, 0);

    // Mult/div: start at cycle 0, busy 1..3, done at 4, md-use stalls 1..4
    for (int c = 0; c <= 5; c++) begin
      cyc_begin();
      IFID_MdUse = 1'b1;
      md_start = (c == 0);
      cyc_check();
      chk("md_busy_seq", md_busy, (c >= 1 && c <= 3));
      chk("md_done_seq", md_done, (c == 4));
      chk("md_stall_seq", IDEX_Flush, (c >= 1 && c <= 4));
    end

    // Reset during BUSY aborts the operation without a done pulse
    cyc_begin(); md_start = 1'b1; cyc_check();
    cyc_begin(); cyc_check();
    chk("abort_busy_pre", md_busy, 1);
    cyc_begin(); cyc_check();
    cyc_begin(); rst = 1'b1; cyc_check();
    chk("abort_busy_rst", md_busy, 0);
    for (int c = 0; c < 6; c++) begin
      cyc_begin(); rst = 1'b0; cyc_check();
      chk("abort_no_done", md_done, 0);
    end

    // Perf counter: three load-use stalls
    do_reset();
    for (int c = 0; c < 3; c++) begin
      cyc_begin();
      IDEX_MemRd = 1'b1; IDEX_Rd = 5'd3; IFID_Rs = 5'd3;
      cyc_check();
    end
    cyc_begin(); cyc_check();
`ifdef STALL_PERF_EN
    chk("perf_three", perf_stall_cnt, 3);
`else
    chk("perf_tied", perf_stall_cnt, 0);
`endif

    // Randomized cycles against the model, with occasional resets
    for (int c = 0; c < 3000; c++) begin
      cyc_begin();
      rst          = ($urandom_range(0, 199) == 0);
      IFID_Rs      = 5'($urandom_range(0, 3));
      IFID_Rt      = 5'($urandom_range(0, 3));
      IFID_UsesRt  = 1'($urandom_range(0, 1));
      IFID_Branch  = 1'($urandom_range(0, 1));
      IFID_MdUse   = 1'($urandom_range(0, 1));
      IDEX_Rd      = 5'($urandom_range(0, 3));
      IDEX_RegWr   = 1'($urandom_range(0, 1));
      IDEX_MemRd   = ($urandom_range(0, 3) == 0);
      EXMEM_Rd     = 5'($urandom_range(0, 3));
      EXMEM_MemRd  = ($urandom_range(0, 3) == 0);
      md_start     = ($urandom_range(0, 5) == 0);
      branch_taken = 1'($urandom_range(0, 1));
      cyc_check();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
